pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter D, default 12, giving the program counter width in bits.
REQ-002 The block SHALL have parameter CW, default 16, giving the cycle counter width in bits.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin program execution at PC 0.
REQ-006 stall  input  1  hold the PC for this cycle.
REQ-007 branch_en  input  1  taken branch this cycle.
REQ-008 branch_idx  input  6  index into the branch target LUT.
REQ-009 halt_req  input  1  the decoder has seen the program-end instruction.
REQ-010 lut_addr  output  6  address driven to the branch target LUT.
REQ-011 lut_target  input  D  combinational LUT result for lut_addr.
REQ-012 pc  output  D  current program counter.
REQ-013 busy  output  1  high while the FSM is in RUN.
REQ-014 done  output  1  high while the FSM is in DONE.
REQ-015 pc_ovf  output  1  sticky flag: PC ran off the top of instruction memory.
REQ-016 cycle_cnt  output  CW  count of RUN cycles in the current or most recent run.

Function
REQ-017 lut_addr SHALL equal branch_idx combinationally in every state.
REQ-018 FSM states SHALL be IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-019 IDLE: start=1 -> RUN next edge, with pc<=0, cycle_cnt<=0 and pc_ovf<=0; otherwise all state holds.
REQ-020 RUN, per edge, in strict priority: halt_req -> DONE; stall -> pc holds; branch_en -> pc<=lut_target; otherwise pc<=pc+1.
REQ-021 RUN with halt_req=1 SHALL hold pc, so pc keeps the address of the halting instruction.
REQ-022 stall SHALL override branch_en in the same cycle; the branch is discarded, and the decoder re-asserts branch_en after the stall.
REQ-023 Branch targets SHALL be taken verbatim from lut_target; an unpopulated index whose target is 0 sends pc to 0 with no error flag.
REQ-024 RUN, increment case, pc = 2^D-1: pc holds, pc_ovf<=1 and state -> DONE instead of wrapping.
REQ-025 A branch to any value, including 2^D-1, SHALL NOT set pc_ovf.
REQ-026 cycle_cnt SHALL increment on every edge spent in RUN, including stall and halting cycles, and saturate at 2^CW-1.
REQ-027 cycle_cnt SHALL hold its value in DONE and IDLE.
REQ-028 start in RUN SHALL be ignored.
REQ-029 DONE: start=1 -> RUN next edge with pc<=0, cycle_cnt<=0 and pc_ovf<=0 (restart); otherwise hold, and halt_req, stall and branch_en are ignored.
REQ-030 Start-to-first-fetch latency SHALL be one cycle: pc=0 is valid in the first cycle busy=1.

Reset
REQ-031 reset_n=0 SHALL immediately, without a clock edge, force state=IDLE, pc=0, cycle_cnt=0 and pc_ovf=0, giving busy=0 and done=0.
REQ-032 Reset asserted mid-RUN SHALL abort the run with no completion indication (done stays 0).
REQ-033 After reset release the block SHALL wait in IDLE for start.

Verification
REQ-034 Reset then start pulse, 5 free-run cycles -> pc sequence 0,1,2,3,4,5; busy=1; cycle_cnt=5.
REQ-035 RUN at pc=7, branch_en=1, branch_idx=3, lut_target=0x040 -> pc=0x040 next edge; lut_addr=3 in that cycle.
REQ-036 RUN at pc=9, stall=1 and branch_en=1 together for 2 cycles, then free-run -> pc 9,9,10; cycle_cnt still increments during the stall.
REQ-037 halt_req=1 at pc=0x020 -> done=1, busy=0, pc holds 0x020; a later start -> pc=0 and cycle_cnt=0 one cycle after.
REQ-038 Force pc=0xFFF in RUN with no branch -> pc holds 0xFFF, pc_ovf=1, done=1.
REQ-039 reset_n pulled low asynchronously mid-RUN at pc=0x055 -> pc=0, busy=0, done=0 before the next clk edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer with an IDLE/RUN/DONE control FSM.
//
// Starting from IDLE or DONE, a start pulse begins a run at PC 0. In RUN the PC
// advances each cycle. The priority order is halt, then stall, then branch,
// then increment. A branch loads the target verbatim from an external
// combinational LUT. Incrementing past the top of instruction memory sets the
// sticky pc_ovf flag and ends the run. The PC does not wrap. cycle_cnt counts
// every RUN cycle and saturates.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset_n    : asynchronous active-low reset
//   start      : begin execution at PC 0 (IDLE/DONE only)
//   stall      : hold the PC this cycle
//   branch_en  : taken branch this cycle
//   branch_idx : index into the branch target LUT
//   halt_req   : program-end instruction seen
//   lut_addr   : LUT address, always equal to branch_idx
//   lut_target : LUT result for lut_addr
//   pc         : current program counter
//   busy       : FSM in RUN
//   done       : FSM in DONE
//   pc_ovf     : sticky PC overflow flag
//   cycle_cnt  : RUN cycles in the current or most recent run
module pc_sequencer #(
  parameter int unsigned D  = 12,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [5:0]    branch_idx,
  input  logic          halt_req,
  output logic [5:0]    lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  pc,
  output logic          busy,
  output logic          done,
  output logic          pc_ovf,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [D-1:0]  PcMax  = '1;
  localparam logic [CW-1:0] CntMax = '1;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        // Ignore stall/branch/halt here; only start matters.
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        // Counted on every RUN edge, including stall and halting cycles.
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (halt_req) begin
          // PC keeps the address of the halting instruction.
          state_d = StDone;
        end else if (stall) begin
          // Any branch this cycle is dropped; the decoder re-issues it.
          pc_d = pc_q;
        end else if (branch_en) begin
          pc_d = lut_target;
        end else if (pc_q == PcMax) begin
          // Ran off the top of instruction memory: stop rather than wrap.
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign lut_addr  = branch_idx;
  assign pc        = pc_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign pc_ovf    = ovf_q;
  assign cycle_cnt = cnt_q;

endmodule
